// File: rtl/controle_medidas_prox_pkg.sv
// Shared constants for the proximity alarm path: FSM encodings, BCD distance
// width, fallback distance and the comparator threshold.
package controle_medidas_prox_pkg;

    localparam int LARGURA_MEDIDA = 12;
    typedef logic [LARGURA_MEDIDA-1:0] medida_t;

    localparam medida_t MEDIDA_FALHA_PADRAO = 12'h999;
    localparam medida_t LIMIAR_PROXIMIDADE  = 12'h010;

    localparam logic [2:0] EST_INICIAL    = 3'd0;
    localparam logic [2:0] EST_MEDE_ESQ   = 3'd1;
    localparam logic [2:0] EST_ESPERA_ESQ = 3'd2;
    localparam logic [2:0] EST_MEDE_DIR   = 3'd3;
    localparam logic [2:0] EST_ESPERA_DIR = 3'd4;
    localparam logic [2:0] EST_INTERVALO  = 3'd5;

    // Timer width able to hold max(a,b)-1; never narrower than one bit.
    function automatic int largura_timer(input int a, input int b);
        int maior;
        maior = (a > b) ? a : b;
        if (maior < 2) begin
            return 1;
        end else begin
            return $clog2(maior);
        end
    endfunction

endpackage

// File: rtl/contador_m_timeout.sv
// Loadable saturating cycle counter with clear, enable and a terminal-count
// flag compared against a run-time limit.
module contador_m_timeout #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic               load,
    input  logic [LARGURA-1:0] valor_carga,
    input  logic [LARGURA-1:0] limite,
    output logic [LARGURA-1:0] contagem,
    output logic               fim
);

    logic [LARGURA-1:0] contagem_r;

    // Count register: clear beats load beats increment; saturates instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem_r <= {LARGURA{1'b0}};
        end else if (clear) begin
            contagem_r <= {LARGURA{1'b0}};
        end else if (load) begin
            contagem_r <= valor_carga;
        end else if (enable && (contagem_r != {LARGURA{1'b1}})) begin
            contagem_r <= contagem_r + LARGURA'(1);
        end else begin
            contagem_r <= contagem_r;
        end
    end

    assign contagem = contagem_r;
    assign fim      = (contagem_r == limite);

endmodule

// File: rtl/controle_medidas_prox.sv
// Alternately triggers the left and right ultrasonic interfaces, latches their
// BCD distances and substitutes a far value when a sensor does not answer.
module controle_medidas_prox
    import controle_medidas_prox_pkg::*;
#(
    parameter int      INTERVALO    = 2500000,
    parameter int      TIMEOUT      = 1500000,
    parameter medida_t MEDIDA_FALHA = 12'h999
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        pronto_esq,
    input  logic [11:0] medida_esq_in,
    input  logic        pronto_dir,
    input  logic [11:0] medida_dir_in,
    output logic        medir_esq,
    output logic        medir_dir,
    output logic [11:0] medida_esq,
    output logic [11:0] medida_dir,
    output logic        libera_alarme,
    output logic        falha_esq,
    output logic        falha_dir,
    output logic [2:0]  db_estado
);

    localparam int TIMER_W = largura_timer(INTERVALO, TIMEOUT);
    localparam logic [TIMER_W-1:0] FIM_TIMEOUT   = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] FIM_INTERVALO = TIMER_W'(INTERVALO - 1);

    logic [2:0]         estado_r, estado_prox_s;
    logic [TIMER_W-1:0] limite_s, contagem_s;
    logic               fim_s, timer_clear_s, timer_en_s;

    logic    medir_esq_r, medir_dir_r, medir_esq_s, medir_dir_s;
    medida_t medida_esq_r, medida_dir_r, medida_esq_s, medida_dir_s;
    logic    falha_esq_r, falha_dir_r, falha_esq_s, falha_dir_s;
    logic    libera_r, libera_s;

    // Timer limit depends on whether we wait for a sensor or rest between rounds.
    always_comb begin
        limite_s   = FIM_TIMEOUT;
        timer_en_s = 1'b0;
        if (estado_r == EST_INTERVALO) begin
            limite_s   = FIM_INTERVALO;
            timer_en_s = 1'b1;
        end else if ((estado_r == EST_ESPERA_ESQ) || (estado_r == EST_ESPERA_DIR)) begin
            limite_s   = FIM_TIMEOUT;
            timer_en_s = 1'b1;
        end else begin
            limite_s   = FIM_TIMEOUT;
            timer_en_s = 1'b0;
        end
    end

    assign timer_clear_s = (estado_prox_s != estado_r);

    contador_m_timeout #(.LARGURA(TIMER_W)) u_timer (
        .clock       (clock),
        .reset       (reset),
        .clear       (timer_clear_s),
        .enable      (timer_en_s),
        .load        (1'b0),
        .valor_carga ({TIMER_W{1'b0}}),
        .limite      (limite_s),
        .contagem    (contagem_s),
        .fim         (fim_s)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_r <= EST_INICIAL;
        end else begin
            estado_r <= estado_prox_s;
        end
    end

    // Next state; dropping ligar abandons whatever was in progress.
    always_comb begin
        estado_prox_s = estado_r;
        if (!ligar) begin
            estado_prox_s = EST_INICIAL;
        end else begin
            case (estado_r)
                EST_INICIAL:    estado_prox_s = EST_MEDE_ESQ;
                EST_MEDE_ESQ:   estado_prox_s = EST_ESPERA_ESQ;
                EST_ESPERA_ESQ: estado_prox_s = (pronto_esq || fim_s) ? EST_MEDE_DIR : EST_ESPERA_ESQ;
                EST_MEDE_DIR:   estado_prox_s = EST_ESPERA_DIR;
                EST_ESPERA_DIR: estado_prox_s = (pronto_dir || fim_s) ? EST_INTERVALO : EST_ESPERA_DIR;
                EST_INTERVALO:  estado_prox_s = fim_s ? EST_MEDE_ESQ : EST_INTERVALO;
                default:        estado_prox_s = EST_INICIAL;
            endcase
        end
    end

    // Next values of the registered outputs; a reply in the expiry cycle beats the timeout.
    always_comb begin
        medir_esq_s  = (estado_prox_s == EST_MEDE_ESQ);
        medir_dir_s  = (estado_prox_s == EST_MEDE_DIR);
        medida_esq_s = medida_esq_r;
        medida_dir_s = medida_dir_r;
        falha_esq_s  = falha_esq_r;
        falha_dir_s  = falha_dir_r;
        libera_s     = libera_r;
        if (!ligar) begin
            libera_s = 1'b0;
        end else if (estado_r == EST_ESPERA_ESQ) begin
            if (pronto_esq) begin
                medida_esq_s = medida_esq_in;
                falha_esq_s  = 1'b0;
            end else if (fim_s) begin
                medida_esq_s = MEDIDA_FALHA;
                falha_esq_s  = 1'b1;
            end else begin
                medida_esq_s = medida_esq_r;
            end
        end else if (estado_r == EST_ESPERA_DIR) begin
            if (pronto_dir) begin
                medida_dir_s = medida_dir_in;
                falha_dir_s  = 1'b0;
                libera_s     = 1'b1;
            end else if (fim_s) begin
                medida_dir_s = MEDIDA_FALHA;
                falha_dir_s  = 1'b1;
                libera_s     = 1'b1;
            end else begin
                medida_dir_s = medida_dir_r;
            end
        end else begin
            libera_s = libera_r;
        end
    end

    // Output registers keep the comparator inputs glitch-free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            medir_esq_r  <= 1'b0;
            medir_dir_r  <= 1'b0;
            medida_esq_r <= MEDIDA_FALHA;
            medida_dir_r <= MEDIDA_FALHA;
            falha_esq_r  <= 1'b0;
            falha_dir_r  <= 1'b0;
            libera_r     <= 1'b0;
        end else begin
            medir_esq_r  <= medir_esq_s;
            medir_dir_r  <= medir_dir_s;
            medida_esq_r <= medida_esq_s;
            medida_dir_r <= medida_dir_s;
            falha_esq_r  <= falha_esq_s;
            falha_dir_r  <= falha_dir_s;
            libera_r     <= libera_s;
        end
    end

    assign medir_esq     = medir_esq_r;
    assign medir_dir     = medir_dir_r;
    assign medida_esq    = medida_esq_r;
    assign medida_dir    = medida_dir_r;
    assign falha_esq     = falha_esq_r;
    assign falha_dir     = falha_dir_r;
    assign libera_alarme = libera_r;
    assign db_estado     = estado_r;

endmodule

// File: tb/tb_controle_medidas_prox.sv
// Directed bench for controle_medidas_prox with a schedule-based reference
// model checked every cycle plus hand-computed literal expectations.
module tb_controle_medidas_prox;

    localparam int INTERVALO_TB = 20;
    localparam int TIMEOUT_TB   = 10;
    localparam logic [11:0] FAR = 12'h999;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ligar = 1'b0;
    logic        pronto_esq = 1'b0;
    logic [11:0] medida_esq_in = 12'h000;
    logic        pronto_dir = 1'b0;
    logic [11:0] medida_dir_in = 12'h000;
    logic        medir_esq, medir_dir, libera_alarme, falha_esq, falha_dir;
    logic [11:0] medida_esq, medida_dir;
    logic [2:0]  db_estado;

    controle_medidas_prox #(
        .INTERVALO(INTERVALO_TB), .TIMEOUT(TIMEOUT_TB), .MEDIDA_FALHA(12'h999)
    ) dut (
        .clock(clock), .reset(reset), .ligar(ligar),
        .pronto_esq(pronto_esq), .medida_esq_in(medida_esq_in),
        .pronto_dir(pronto_dir), .medida_dir_in(medida_dir_in),
        .medir_esq(medir_esq), .medir_dir(medir_dir),
        .medida_esq(medida_esq), .medida_dir(medida_dir),
        .libera_alarme(libera_alarme), .falha_esq(falha_esq), .falha_dir(falha_dir),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Reference model: tracks which reply is awaited, its acceptance window and
    // the cycle number of the next trigger.
    longint      m_cyc, m_lo, m_hi, m_trig_at;
    int          m_wait, m_trig_side;
    bit          m_run;
    logic        e_medir_esq, e_medir_dir, e_libera, e_falha_esq, e_falha_dir;
    logic [11:0] e_med_esq, e_med_dir;
    logic [2:0]  e_estado;

    always @(posedge clock or posedge reset) begin : model
        longint now, lo, hi, ta;
        int w, ts;
        bit r, done;
        logic mes, mdr, lib, fe, fd;
        logic [11:0] me, md;
        logic [2:0] st;
        if (reset) begin
            m_cyc <= 0; m_lo <= 0; m_hi <= 0; m_trig_at <= 0;
            m_wait <= 0; m_trig_side <= 0; m_run <= 1'b0;
            e_medir_esq <= 1'b0; e_medir_dir <= 1'b0; e_libera <= 1'b0;
            e_falha_esq <= 1'b0; e_falha_dir <= 1'b0;
            e_med_esq <= FAR; e_med_dir <= FAR; e_estado <= 3'd0;
        end else begin
            now = m_cyc; lo = m_lo; hi = m_hi; ta = m_trig_at;
            w = m_wait; ts = m_trig_side; r = m_run;
            me = e_med_esq; md = e_med_dir; fe = e_falha_esq; fd = e_falha_dir;
            lib = e_libera; mes = 1'b0; mdr = 1'b0; st = 3'd0; done = 1'b0;
            if (!ligar) begin
                r = 1'b0; w = 0; ts = 0; lib = 1'b0;
            end else begin
                if (!r) begin
                    r = 1'b1; ts = 1; ta = now + 1;
                end else if (w == 1 && now >= lo) begin
                    if (pronto_esq) begin me = medida_esq_in; fe = 1'b0; done = 1'b1; end
                    else if (now == hi) begin me = FAR; fe = 1'b1; done = 1'b1; end
                    if (done) begin w = 0; ts = 2; ta = now + 1; end
                end else if (w == 2 && now >= lo) begin
                    if (pronto_dir) begin md = medida_dir_in; fd = 1'b0; done = 1'b1; end
                    else if (now == hi) begin md = FAR; fd = 1'b1; done = 1'b1; end
                    if (done) begin w = 0; ts = 1; ta = now + 1 + INTERVALO_TB; lib = 1'b1; end
                end
                if (ts != 0 && ta == now + 1) begin
                    if (ts == 1) mes = 1'b1; else mdr = 1'b1;
                    st = (ts == 1) ? 3'd1 : 3'd3;
                    w = ts; lo = now + 2; hi = now + 1 + TIMEOUT_TB; ts = 0;
                end else if (w != 0) begin
                    st = (w == 1) ? 3'd2 : 3'd4;
                end else if (ts != 0) begin
                    st = 3'd5;
                end
            end
            m_cyc <= now + 1; m_lo <= lo; m_hi <= hi; m_trig_at <= ta;
            m_wait <= w; m_trig_side <= ts; m_run <= r;
            e_medir_esq <= mes; e_medir_dir <= mdr; e_libera <= lib;
            e_falha_esq <= fe; e_falha_dir <= fd;
            e_med_esq <= me; e_med_dir <= md; e_estado <= st;
        end
    end

    // Literal expectations queued by the stimulus, consumed by the compare process.
    string       lit_name [0:127];
    int          lit_sig  [0:127];
    logic [11:0] lit_val  [0:127];
    int          lit_wr = 0;
    int          lit_rd = 0;
    bit          chk_on = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [11:0] dut_val(input int sig);
        case (sig)
            0: return {11'd0, medir_esq};
            1: return {11'd0, medir_dir};
            2: return medida_esq;
            3: return medida_dir;
            4: return {11'd0, libera_alarme};
            5: return {11'd0, falha_esq};
            6: return {11'd0, falha_dir};
            7: return {9'd0, db_estado};
            default: return 12'hfff;
        endcase
    endfunction

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
        end
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            check("model medir_esq",  dut_val(0), {11'd0, e_medir_esq});
            check("model medir_dir",  dut_val(1), {11'd0, e_medir_dir});
            check("model medida_esq", dut_val(2), e_med_esq);
            check("model medida_dir", dut_val(3), e_med_dir);
            check("model libera",     dut_val(4), {11'd0, e_libera});
            check("model falha_esq",  dut_val(5), {11'd0, e_falha_esq});
            check("model falha_dir",  dut_val(6), {11'd0, e_falha_dir});
            check("model db_estado",  dut_val(7), {9'd0, e_estado});
            while (lit_rd < lit_wr) begin
                check(lit_name[lit_rd], dut_val(lit_sig[lit_rd]), lit_val[lit_rd]);
                lit_rd++;
            end
        end
    end

    localparam int S_MESQ = 0, S_MDIR = 1, S_DESQ = 2, S_DDIR = 3,
                   S_LIB = 4, S_FESQ = 5, S_FDIR = 6, S_EST = 7;

    task automatic expect_lit(input string nm, input int sig, input logic [11:0] v);
        lit_name[lit_wr] = nm;
        lit_sig[lit_wr]  = sig;
        lit_val[lit_wr]  = v;
        lit_wr++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (3) tick();
        chk_on = 1'b1;
        expect_lit("reset medida_esq", S_DESQ, 12'h999);
        expect_lit("reset medida_dir", S_DDIR, 12'h999);
        expect_lit("reset libera",     S_LIB,  12'h000);
        expect_lit("reset estado",     S_EST,  12'h000);
        ligar = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        expect_lit("first trigger",    S_MESQ, 12'h001);
        expect_lit("first mede_esq",   S_EST,  12'h001);
        tick();
        expect_lit("trigger one cycle", S_MESQ, 12'h000);
        expect_lit("espera_esq",       S_EST,  12'h002);
        tick();
        tick();
        pronto_esq = 1'b1; medida_esq_in = 12'h025;
        tick();
        pronto_esq = 1'b0;
        expect_lit("left latched",     S_DESQ, 12'h025);
        expect_lit("right trigger",    S_MDIR, 12'h001);
        tick();
        pronto_dir = 1'b1; medida_dir_in = 12'h008;
        expect_lit("espera_dir",       S_EST,  12'h004);
        tick();
        pronto_dir = 1'b0;
        expect_lit("right latched",    S_DDIR, 12'h008);
        expect_lit("alarm enabled",    S_LIB,  12'h001);
        expect_lit("intervalo",        S_EST,  12'h005);
        repeat (19) tick();
        expect_lit("no early trigger", S_MESQ, 12'h000);
        tick();
        expect_lit("trigger after 20", S_MESQ, 12'h001);
        // left silent, spurious right reply ignored, right silent too
        tick();
        tick();
        pronto_dir = 1'b1; medida_dir_in = 12'h001;
        tick();
        pronto_dir = 1'b0;
        expect_lit("spurious dir held", S_DDIR, 12'h008);
        expect_lit("spurious no move",  S_EST,  12'h002);
        repeat (8) tick();
        expect_lit("left timeout far",  S_DESQ, 12'h999);
        expect_lit("left timeout flag", S_FESQ, 12'h001);
        expect_lit("trigger after tmo", S_MDIR, 12'h001);
        repeat (11) tick();
        expect_lit("right timeout far",  S_DDIR, 12'h999);
        expect_lit("right timeout flag", S_FDIR, 12'h001);
        repeat (20) tick();
        expect_lit("round3 trigger",    S_MESQ, 12'h001);
        tick();
        pronto_esq = 1'b1; medida_esq_in = 12'h321;
        tick();
        pronto_esq = 1'b0;
        expect_lit("left reply clears", S_FESQ, 12'h000);
        expect_lit("left value 321",    S_DESQ, 12'h321);
        repeat (10) tick();
        pronto_dir = 1'b1; medida_dir_in = 12'h150;
        tick();
        pronto_dir = 1'b0;
        expect_lit("pronto wins value", S_DDIR, 12'h150);
        expect_lit("pronto wins flag",  S_FDIR, 12'h000);
        // ligar dropped while waiting on the right sensor
        repeat (20) tick();
        tick();
        tick();
        pronto_esq = 1'b1; medida_esq_in = 12'h047;
        tick();
        pronto_esq = 1'b0;
        tick();
        tick();
        ligar = 1'b0;
        tick();
        expect_lit("off inicial",       S_EST,  12'h000);
        expect_lit("off libera",        S_LIB,  12'h000);
        expect_lit("off keeps esq",     S_DESQ, 12'h047);
        expect_lit("off keeps dir",     S_DDIR, 12'h150);
        pronto_esq = 1'b1; medida_esq_in = 12'h123;
        tick();
        pronto_esq = 1'b0;
        expect_lit("idle ignores esq",  S_DESQ, 12'h047);
        ligar = 1'b1;
        tick();
        expect_lit("restart trigger",   S_MESQ, 12'h001);
        tick();
        pronto_esq = 1'b1; medida_esq_in = 12'h200;
        tick();
        pronto_esq = 1'b0;
        expect_lit("libera still low",  S_LIB,  12'h000);
        tick();
        pronto_dir = 1'b1; medida_dir_in = 12'h099;
        tick();
        pronto_dir = 1'b0;
        expect_lit("libera again",      S_LIB,  12'h001);
        expect_lit("restart right val", S_DDIR, 12'h099);
        // asynchronous reset in the middle of a cycle
        tick();
        #2;
        reset = 1'b1;
        expect_lit("async rst esq",     S_DESQ, 12'h999);
        expect_lit("async rst libera",  S_LIB,  12'h000);
        expect_lit("async rst estado",  S_EST,  12'h000);
        tick();
        tick();
        reset = 1'b0;
        tick();
        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
